// File: rtl/combo_lock_n_if.sv
// Keypad/display bundle for the combination lock.
// master: drives digit_in/enter/clear; slave: drives hex_out/unlocked/locked_out.
interface combo_lock_n_if;
  logic [3:0]  digit_in;
  logic        enter;
  logic        clear;
  logic [41:0] hex_out;
  logic        unlocked;
  logic        locked_out;

  modport master (
    output digit_in, enter, clear,
    input  hex_out, unlocked, locked_out
  );

  modport slave (
    input  digit_in, enter, clear,
    output hex_out, unlocked, locked_out
  );
endinterface

// File: rtl/combo_lock_n.sv
// Digit-entry combination lock with 6-digit 7-segment status display.
// Ports: clock, reset (async active-low), bus (combo_lock_n_if.slave).
// Optional lockout after MAX_TRIES failures: define COMBO_LOCK_LOCKOUT_EN.
module combo_lock_n #(
  parameter int                      NUM_DIGITS = 6,
  parameter logic [4*NUM_DIGITS-1:0] CODE       = 24'h392017,
  parameter int                      MAX_TRIES  = 3
) (
  input logic           clock,
  input logic           reset,
  combo_lock_n_if.slave bus
);

`ifdef COMBO_LOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_O   = 7'b1000000;
  localparam logic [6:0] SEG_P   = 7'b0001100;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_N   = 7'b0101011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_L   = 7'b1000111;
  localparam logic [6:0] SEG_S   = 7'b0010010;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    S_ENTRY,
    S_OPEN,
    S_CLOSED,
    S_LOCKED
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       mis_q, mis_d;
  logic [3:0] fail_q, fail_d;
  // last_q[4] marks a digit as shown; clear means blank.
  logic [4:0] last_q, last_d;

  logic [4*NUM_DIGITS-1:0] code_sh;
  logic [3:0]              exp_nib;
  logic                    bad;
  logic [3:0]              fail_inc;
  logic                    lock_hit;

  function automatic logic [6:0] seg_dig(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_ENTRY;
      cnt_q   <= 3'd0;
      mis_q   <= 1'b0;
      fail_q  <= 4'd0;
      last_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      fail_q  <= fail_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    // First entered digit sits in the top nibble.
    code_sh  = CODE >> (4 * (NUM_DIGITS - 1 - int'(cnt_q)));
    exp_nib  = code_sh[3:0];
    bad      = (bus.digit_in > 4'd9) || (bus.digit_in != exp_nib);
    fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
    lock_hit = LOCK_EN && (fail_inc >= 4'(MAX_TRIES));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    fail_d  = fail_q;
    last_d  = last_q;
    unique case (state_q)
      S_ENTRY: begin
        if (bus.clear) begin
          cnt_d  = 3'd0;
          mis_d  = 1'b0;
          last_d = 5'd0;
        end else if (bus.enter) begin
          last_d = {1'b1, bus.digit_in};
          if (cnt_q == LAST) begin
            cnt_d = 3'd0;
            mis_d = 1'b0;
            if (!(mis_q || bad)) begin
              state_d = S_OPEN;
              fail_d  = 4'd0;
            end else begin
              fail_d  = fail_inc;
              state_d = lock_hit ? S_LOCKED : S_CLOSED;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            mis_d = mis_q | bad;
          end
        end
      end
      S_OPEN, S_CLOSED: begin
        if (bus.clear) begin
          state_d = S_ENTRY;
          last_d  = 5'd0;
        end
      end
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
      default: state_d = S_ENTRY;
    endcase
  end

  always_comb begin
    bus.hex_out = {42{1'b1}};
    unique case (state_q)
      S_ENTRY: begin
        if (last_q[4]) begin
          bus.hex_out[6:0] = seg_dig(last_q[3:0]);
        end
      end
      S_OPEN: begin
        bus.hex_out[27:0] = {SEG_O, SEG_P, SEG_E, SEG_N};
      end
      S_CLOSED: begin
        bus.hex_out = {SEG_C, SEG_L, SEG_O, SEG_S, SEG_E, SEG_D};
      end
      S_LOCKED: begin
        bus.hex_out[27:0] = {SEG_L, SEG_O, SEG_C, SEG_D};
      end
      default: bus.hex_out = {42{1'b1}};
    endcase
  end

  assign bus.unlocked = (state_q == S_OPEN);

`ifdef COMBO_LOCK_LOCKOUT_EN
  assign bus.locked_out = (state_q == S_LOCKED);
`else
  assign bus.locked_out = 1'b0;
`endif

  logic unused_off;
  assign unused_off = ^SEG_OFF;

endmodule

// File: doc/combo_lock_n.md
COMBO_LOCK_N -- requirements
Module: combo_lock_n

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of digits in the code, legal range 1..8.
REQ-002 Parameter CODE, default 24'h392017: code, 4*NUM_DIGITS bits packed; most significant nibble is the first digit entered.
REQ-003 Parameter MAX_TRIES, default 3: consecutive failed attempts before lockout, legal range 1..15.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 digit_in  input  4  digit presented for entry, 0..9 valid.
REQ-007 enter  input  1  when high at a clock edge, digit_in is consumed as one entry.
REQ-008 clear  input  1  when high at a clock edge, aborts entry or result and returns to ENTRY; takes priority over enter.
REQ-009 hex_out  output  42  six active-low 7-segment digits; HEX0 is bits [6:0], HEX5 is bits [41:35].
REQ-010 unlocked  output  1  high only in state OPEN.
REQ-011 locked_out  output  1  high only in state LOCKED.

Function
REQ-012 The block SHALL implement states ENTRY, OPEN, CLOSED and LOCKED, with all state held in registers updated on the rising clock edge.
REQ-013 In ENTRY, each enter SHALL increment the entry counter (0..NUM_DIGITS-1) and set a sticky mismatch flag if digit_in is greater than 9 or differs from the corresponding CODE nibble.
REQ-014 On the enter that completes entry NUM_DIGITS, the next state SHALL be OPEN if no mismatch occurred, otherwise CLOSED; the counter and flag SHALL clear on the same edge.
REQ-015 Entering OPEN SHALL zero the failure counter; entering CLOSED SHALL increment it, saturating at 15.
REQ-016 In OPEN and CLOSED, enter SHALL be ignored; only clear returns to ENTRY.
REQ-017 clear in ENTRY SHALL discard partial entry without counting a failure.
REQ-018 hex_out SHALL be a combinational decode of registers only, never of digit_in directly.
REQ-019 In ENTRY, HEX0 SHALL show the last accepted digit (blank before the first, "E" if that digit exceeded 9) and HEX5..HEX1 SHALL be blank.
REQ-020 In OPEN, HEX3..HEX0 SHALL show "OPEn" and HEX5..HEX4 SHALL be blank; in CLOSED, HEX5..HEX0 SHALL show "CLOSEd".
REQ-021 Segment codes (gfedcba, active-low):
- digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000
- O 1000000, P 0001100, E 0000110, n 0101011, C 1000110, L 1000111, S 0010010, d 0100001, blank 1111111

Reset
REQ-022 While reset is low, the block SHALL asynchronously force state ENTRY, entry counter 0, mismatch flag 0, failure counter 0 and last digit blank.
REQ-023 During reset, outputs SHALL be hex_out all ones, unlocked 0 and locked_out 0.
REQ-024 Reset asserted mid-entry or in LOCKED SHALL override every other input, and enter SHALL be ignored on the first edge after release only if it coincides with release.

Configuration
REQ-025 With macro COMBO_LOCK_LOCKOUT_EN defined, entering CLOSED with the failure counter reaching MAX_TRIES SHALL go to LOCKED instead.
REQ-026 With COMBO_LOCK_LOCKOUT_EN defined, LOCKED SHALL ignore enter and clear, exit only on reset, and show "LOCd" on HEX3..HEX0 with HEX5..HEX4 blank.
REQ-027 Without COMBO_LOCK_LOCKOUT_EN, LOCKED SHALL be unreachable, locked_out SHALL be tied 0, and the failure counter may be omitted.

Verification
REQ-028 Defaults: reset, then enter 3,9,2,0,1,7 -> after the 6th edge unlocked=1 and hex_out[27:0] shows "OPEn".
REQ-029 Enter 3,9,2,0,1,8 -> CLOSED, hex_out shows "CLOSEd", unlocked=0; then clear -> ENTRY with HEX0 blank.
REQ-030 Enter 5 -> HEX0=0010010; enter digit_in=12 -> HEX0=0000110 and the attempt ends in CLOSED after 6 entries.
REQ-031 Assert enter and clear on the same edge mid-entry -> counter 0, no failure counted, and a subsequent correct code opens.
REQ-032 With COMBO_LOCK_LOCKOUT_EN, three wrong attempts -> locked_out=1 and "LOCd"; correct code and clear are ignored; reset -> ENTRY.
REQ-033 Reset pulsed low mid-clock after three digits -> immediate blank display; a full correct code afterwards opens.
